// File: rtl/frame_seq_pkg.sv
// Shared types and helpers for the frame sequencer.
package frame_seq_pkg;

  // Sequencer states; the encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHOW     = 3'd2,
    ST_WAIT_EOF = 3'd3,
    ST_SWAP     = 3'd4
  } state_t;

  // Next bank index, wrapping to 0 after the last bank.
  function automatic int unsigned bank_inc(input int unsigned sel, input int unsigned num);
    return (sel + 1 >= num) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Display-side signal bundle between the frame sequencer and its environment.
//
// Signalling: in_frame_done and in_step are single-cycle pulses, sampled on
// the rising clock edge with no back-pressure. out_valid is a level meaning
// "the selected bank is charged and on screen"; out_switch is a one-cycle
// pulse on the cycle out_sel takes its new value. in_rd / out_bank_rd form a
// combinational pass-through strobe with no handshake of their own.
interface frame_sequencer_if #(
  parameter int NUM_FRAMES = 2,
  parameter int TIMER_W    = 24
);
  import frame_seq_pkg::*;

  localparam int SEL_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic                  in_enable;
  logic                  in_step;
  logic [TIMER_W-1:0]    in_period;
  logic                  in_frame_done;
  logic                  in_rd;
  logic [NUM_FRAMES-1:0] in_charged;
  logic [SEL_W-1:0]      out_sel;
  logic [NUM_FRAMES-1:0] out_bank_rd;
  logic [NUM_FRAMES-1:0] out_bank_rst;
  logic                  out_switch;
  logic                  out_valid;
  state_t                state;

  modport master (
    output in_enable, in_step, in_period, in_frame_done, in_rd, in_charged,
    input  out_sel, out_bank_rd, out_bank_rst, out_switch, out_valid, state
  );

  modport slave (
    input  in_enable, in_step, in_period, in_frame_done, in_rd, in_charged,
    output out_sel, out_bank_rd, out_bank_rst, out_switch, out_valid, state
  );

endinterface

// File: rtl/frame_period_timer.sv
// Saturating display-period counter with clear/enable and a terminal flag.
module frame_period_timer #(
  parameter int TIMER_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] period,
  output logic               terminal
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] limit;

  // A period of 0 behaves like 1, so the last count is max(period,1)-1.
  always_comb begin
    limit    = (period == '0) ? '0 : period - TIMER_W'(1);
    terminal = (count >= limit);
  end

  // Count up while enabled, holding at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Sequences a bank of frame VRAMs: picks the displayed bank, steers the read
// strobe to it, and advances at end-of-frame once the display period expires.
module frame_sequencer #(
  parameter int NUM_FRAMES = 2,
  parameter int TIMER_W    = 24
) (
  input logic               clk,
  input logic               rst,
  frame_sequencer_if.slave  bus
);
  import frame_seq_pkg::*;

  localparam int SEL_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [NUM_FRAMES-1:0] ONE = NUM_FRAMES'(1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [SEL_W-1:0] prev_sel, prev_sel_nxt;
  logic [SEL_W-1:0] inc_sel;
  logic             pending, pending_nxt;
  logic             timer_clr, timer_en, terminal;

  frame_period_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .en       (timer_en),
    .period   (bus.in_period),
    .terminal (terminal)
  );

  // State, displayed bank, bank being reloaded, and the advance request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      sel      <= '0;
      prev_sel <= '0;
      pending  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      prev_sel <= prev_sel_nxt;
      pending  <= pending_nxt;
    end
  end

  // Next-state logic; out_sel moves on the frame_done edge so SWAP shows the new bank.
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    prev_sel_nxt = prev_sel;
    pending_nxt  = pending;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    inc_sel      = SEL_W'(bank_inc(32'(sel), NUM_FRAMES));
    case (state)
      ST_INIT: state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (bus.in_charged[sel]) begin
          state_nxt = ST_SHOW;
          timer_clr = 1'b1;
        end
      end
      ST_SHOW: begin
        timer_en = bus.in_enable && !terminal;
        if (pending) begin
          state_nxt = ST_WAIT_EOF;
        end else if ((bus.in_enable && terminal) || (!bus.in_enable && bus.in_step)) begin
          pending_nxt = 1'b1;
        end
      end
      ST_WAIT_EOF: begin
        if (bus.in_frame_done) begin
          if (NUM_FRAMES == 1) begin
            // Single bank: nothing to swap to, just start a new period.
            pending_nxt = 1'b0;
            timer_clr   = 1'b1;
            state_nxt   = ST_SHOW;
          end else if (bus.in_charged[inc_sel]) begin
            prev_sel_nxt = sel;
            sel_nxt      = inc_sel;
            state_nxt    = ST_SWAP;
          end
        end
      end
      ST_SWAP: begin
        pending_nxt = 1'b0;
        timer_clr   = 1'b1;
        state_nxt   = ST_SHOW;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Output decode: read steering, reload requests, status.
  always_comb begin
    bus.out_sel      = sel;
    bus.out_bank_rd  = bus.in_rd ? (ONE << sel) : '0;
    bus.out_bank_rst = '0;
    if (state == ST_INIT) begin
      bus.out_bank_rst = '1;
    end else if (state == ST_SWAP) begin
      bus.out_bank_rst = ONE << prev_sel;
    end
    bus.out_switch = (state == ST_SWAP);
    bus.out_valid  = (state == ST_SHOW) || (state == ST_WAIT_EOF) || (state == ST_SWAP);
    bus.state      = state;
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a behavioural model.
module tb_frame_sequencer;

  localparam int NF = 2;
  localparam int TW = 24;

  // Behavioural phases of the display controller.
  localparam int P_INIT = 0;
  localparam int P_LOAD = 1;
  localparam int P_SHOW = 2;
  localparam int P_WAIT = 3;
  localparam int P_SWAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  // Model: phase, shown bank, bank left at the last swap, elapsed period, advance request.
  int m_phase, m_sel, m_old, m_cnt;
  bit m_pend;

  frame_sequencer_if #(.NUM_FRAMES(NF), .TIMER_W(TW)) bus();

  frame_sequencer #(.NUM_FRAMES(NF), .TIMER_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_INIT;
    m_sel   = 0;
    m_old   = 0;
    m_cnt   = 0;
    m_pend  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    int lim, nxt;
    if (!rst) begin
      model_reset();
      return;
    end
    lim = (bus.in_period == 0) ? 1 : int'(bus.in_period);
    case (m_phase)
      P_INIT: m_phase = P_LOAD;
      P_LOAD: if (bus.in_charged[m_sel]) begin
        m_phase = P_SHOW;
        m_cnt   = 0;
        m_pend  = 1'b0;
      end
      P_SHOW: begin
        if (m_pend) m_phase = P_WAIT;
        else if (bus.in_enable) begin
          if (m_cnt >= lim - 1) m_pend = 1'b1;
          else m_cnt++;
        end else if (bus.in_step) m_pend = 1'b1;
      end
      P_WAIT: if (bus.in_frame_done) begin
        nxt = (m_sel + 1) % NF;
        if (NF == 1) begin
          m_pend = 1'b0; m_cnt = 0; m_phase = P_SHOW;
        end else if (bus.in_charged[nxt]) begin
          m_old = m_sel; m_sel = nxt; m_phase = P_SWAP;
        end
      end
      P_SWAP: begin
        m_pend = 1'b0; m_cnt = 0; m_phase = P_SHOW;
      end
      default: model_reset();
    endcase
  endtask

  task automatic check_all();
    int exp_rd, exp_rst;
    exp_rd = bus.in_rd ? (1 << m_sel) : 0;
    if (m_phase == P_INIT) exp_rst = (1 << NF) - 1;
    else if (m_phase == P_SWAP) exp_rst = 1 << m_old;
    else exp_rst = 0;
    check("sel",      32'(bus.out_sel),      32'(m_sel));
    check("bank_rd",  32'(bus.out_bank_rd),  32'(exp_rd));
    check("bank_rst", 32'(bus.out_bank_rst), 32'(exp_rst));
    check("switch",   32'(bus.out_switch),   32'(m_phase == P_SWAP));
    check("valid",    32'(bus.out_valid),
          32'((m_phase == P_SHOW) || (m_phase == P_WAIT) || (m_phase == P_SWAP)));
  endtask

  // One clock: model update at the edge, compare shortly after, return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Assert reset between edges and confirm the outputs drop without a clock.
  task automatic async_reset();
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
  endtask

  task automatic set_inputs(input bit en, input int period, input logic [NF-1:0] chg);
    bus.in_enable     = en;
    bus.in_step       = 1'b0;
    bus.in_period     = TW'(period);
    bus.in_frame_done = 1'b0;
    bus.in_rd         = 1'b0;
    bus.in_charged    = chg;
  endtask

  initial begin
    int sw, first_i;
    int sel_hist[$];
    int first_sw[2];

    // Clock/reset: hold reset with all-ones charge.
    set_inputs(1'b1, 4, 2'b11);
    model_reset();
    @(negedge clk);
    #1 check_all();
    repeat (3) cycle();
    rst = 1'b1;

    // 1: free-running alternation, frame_done every 10 cycles.
    sw = 0;
    for (int i = 0; i < 60; i++) begin
      bus.in_frame_done = (i % 10 == 9);
      cycle();
      if (bus.out_switch) begin
        sw++;
        sel_hist.push_back(int'(bus.out_sel));
      end
    end
    bus.in_frame_done = 1'b0;
    check("s1_switches", 32'(sw), 32'(6));
    check("s1_sel_a", 32'(sel_hist[0]), 32'(1));
    check("s1_sel_b", 32'(sel_hist[1]), 32'(0));
    check("s1_sel_c", 32'(sel_hist[2]), 32'(1));

    // 2: bank 1 uncharged until cycle 60.
    async_reset();
    repeat (2) cycle();
    set_inputs(1'b1, 4, 2'b01);
    rst = 1'b1;
    first_i = -1;
    for (int i = 0; i < 100; i++) begin
      if (i == 60) bus.in_charged = 2'b11;
      bus.in_frame_done = (i % 10 == 9);
      cycle();
      if (bus.out_switch && first_i < 0) first_i = i;
    end
    bus.in_frame_done = 1'b0;
    check("s2_first_swap", 32'(first_i), 32'(69));

    // 3: paused, then one step, then a step while enabled.
    async_reset();
    repeat (2) cycle();
    set_inputs(1'b0, 4, 2'b11);
    rst = 1'b1;
    sw = 0;
    for (int i = 0; i < 200; i++) begin
      bus.in_frame_done = (i % 10 == 9);
      cycle();
      if (bus.out_switch) sw++;
    end
    check("s3_paused", 32'(sw), 32'(0));
    bus.in_frame_done = 1'b0;
    bus.in_step = 1'b1;
    cycle();
    bus.in_step = 1'b0;
    sw = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_frame_done = (i % 10 == 9);
      cycle();
      if (bus.out_switch) sw++;
    end
    check("s3_one_step", 32'(sw), 32'(1));
    bus.in_enable = 1'b1;
    bus.in_period = TW'(1000);
    bus.in_frame_done = 1'b0;
    bus.in_step = 1'b1;
    sw = 0;
    cycle();
    if (bus.out_switch) sw++;
    bus.in_step = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.in_frame_done = (i % 10 == 9);
      cycle();
      if (bus.out_switch) sw++;
    end
    bus.in_frame_done = 1'b0;
    check("s3_step_enabled", 32'(sw), 32'(0));

    // 4: period 0 and period 1 give the same swap time.
    for (int p = 0; p < 2; p++) begin
      async_reset();
      repeat (2) cycle();
      set_inputs(1'b1, p, 2'b11);
      bus.in_frame_done = 1'b1;
      rst = 1'b1;
      first_sw[p] = -1;
      for (int i = 0; i < 20; i++) begin
        cycle();
        if (bus.out_switch) begin
          first_sw[p] = i;
          break;
        end
      end
      check("s4_swap_time", 32'(first_sw[p]), 32'(4));
    end
    check("s4_same_timing", 32'(first_sw[1]), 32'(first_sw[0]));

    // 5: read strobe steered to bank 1 combinationally.
    bus.in_frame_done = 1'b0;
    bus.in_rd = 1'b1;
    #1 check("s5_rd_on", 32'(bus.out_bank_rd), 32'(2'b10));
    bus.in_rd = 1'b0;
    #1 check("s5_rd_off", 32'(bus.out_bank_rd), 32'(2'b00));

    // 6: reset while waiting for end-of-frame on bank 1.
    bus.in_period = TW'(1);
    repeat (4) cycle();
    check("s6_pre_sel", 32'(bus.out_sel), 32'(1));
    bus.in_charged = 2'b10;
    async_reset();
    check("s6_sel", 32'(bus.out_sel), 32'(0));
    check("s6_bank_rst", 32'(bus.out_bank_rst), 32'(2'b11));
    check("s6_valid", 32'(bus.out_valid), 32'(0));
    repeat (2) cycle();
    rst = 1'b1;
    repeat (5) cycle();
    check("s6_valid_wait", 32'(bus.out_valid), 32'(0));
    bus.in_charged = 2'b11;
    repeat (3) cycle();
    check("s6_valid_up", 32'(bus.out_valid), 32'(1));

    // Randomized traffic with occasional mid-operation resets.
    for (int i = 0; i < 3000; i++) begin
      bus.in_enable     = ($urandom_range(0, 9) != 0);
      bus.in_step       = ($urandom_range(0, 15) == 0);
      bus.in_period     = TW'($urandom_range(0, 6));
      bus.in_frame_done = ($urandom_range(0, 5) == 0);
      bus.in_rd         = 1'($urandom_range(0, 1));
      for (int b = 0; b < NF; b++) bus.in_charged[b] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        cycle();
        rst = 1'b1;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
